// File: rtl/pin_rx_pkg.sv
// Shared definitions for the pin-level host link receiver.
// Default widths, derived beat count, deframer states, framing bit indices.
package pin_rx_pkg;

    localparam int PIN_W_DEF  = 2;
    localparam int DATA_W_DEF = 16;
    localparam int BEATS_DEF  = DATA_W_DEF / PIN_W_DEF;

    // Line position of the start marker and of the even-parity bit.
    localparam int START_BIT  = 0;
    localparam int PARITY_BIT = 0;

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        PARITY
    } rx_state_e;

endpackage

// File: rtl/pin_rx_fifo2.sv
// Two-entry FIFO between the deframer and the word consumer.
// Ports: push/push_data in, pop in, pop_data (head), full, empty, drop.
module pin_rx_fifo2 #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    output logic [W-1:0] pop_data,
    output logic         full,
    output logic         empty,
    output logic         drop
);

    logic [W-1:0] mem [2];
    logic         wr_ptr;
    logic         rd_ptr;
    logic [1:0]   count;
    logic         do_pop;
    logic         do_push;

    assign full     = (count == 2'd2);
    assign empty    = (count == 2'd0);
    assign do_pop   = pop && !empty;
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign do_push  = push && (!full || do_pop);
    assign drop     = push && full && !do_pop;
    assign pop_data = mem[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem[0] <= '0;
            mem[1] <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= ~wr_ptr;
            end
            if (do_pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/pin_word_rx.sv
// Pin-level host link receiver: deframes PIN_W-bit beats into DATA_W-bit
// words, checks even parity, buffers two words, sticky error flags.
// Ports: clk, rst, enable, rx_pins in; out_data/out_valid/out_ready word
// handshake; err_parity, err_overflow sticky flags; err_clear in.
module pin_word_rx
    import pin_rx_pkg::*;
#(
    parameter int PIN_W  = PIN_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic [PIN_W-1:0]  rx_pins,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              err_parity,
    output logic              err_overflow,
    input  logic              err_clear
);

    localparam int BEATS = DATA_W / PIN_W;
    localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

    rx_state_e         state;
    rx_state_e         state_nx;
    logic [PIN_W-1:0]  in_q;
    logic [DATA_W-1:0] word;
    logic [CNT_W-1:0]  cnt;
    logic              push_ok;
    logic              par_bad;
    logic              fifo_full;
    logic              fifo_empty;
    logic              fifo_drop;
    logic              ovf_evt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            in_q  <= '0;
            state <= IDLE;
            word  <= '0;
            cnt   <= '0;
        end else begin
            in_q  <= rx_pins;
            state <= state_nx;
            if (state == IDLE) begin
                cnt <= '0;
            end else if (state == DATA && enable) begin
                // LSB-first: each beat enters at the top and slides down.
                word <= {in_q, word[DATA_W-1:PIN_W]};
                cnt  <= cnt + 1'b1;
            end
        end
    end

    always_comb begin
        state_nx = state;
        push_ok  = 1'b0;
        par_bad  = 1'b0;
        if (!enable) begin
            state_nx = IDLE;
        end else begin
            unique case (state)
                IDLE: begin
                    if (in_q[START_BIT]) state_nx = DATA;
                end
                DATA: begin
                    if (cnt == LAST_BEAT) state_nx = PARITY;
                end
                PARITY: begin
                    state_nx = IDLE;
                    if (in_q[PARITY_BIT] == ^word) push_ok = 1'b1;
                    else                           par_bad = 1'b1;
                end
                default: state_nx = IDLE;
            endcase
        end
    end

    pin_rx_fifo2 #(
        .W(DATA_W)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push_ok),
        .push_data (word),
        .pop       (out_ready),
        .pop_data  (out_data),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .drop      (fifo_drop)
    );

    assign out_valid = !fifo_empty;
    assign ovf_evt   = fifo_drop && fifo_full;

    // Sticky flags: a new event beats a clear arriving in the same cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_parity   <= 1'b0;
            err_overflow <= 1'b0;
        end else begin
            if (par_bad)        err_parity <= 1'b1;
            else if (err_clear) err_parity <= 1'b0;
            if (ovf_evt)        err_overflow <= 1'b1;
            else if (err_clear) err_overflow <= 1'b0;
        end
    end

endmodule

// File: tb/tb_pin_word_rx.sv
// Directed bench for pin_word_rx: framing, parity, FIFO, enable, reset.
// Inputs change 1 time unit after posedge; outputs sampled there too.
module tb_pin_word_rx;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic [1:0]  rx_pins;
    logic [15:0] out_data;
    logic        out_valid;
    logic        out_ready;
    logic        err_parity;
    logic        err_overflow;
    logic        err_clear;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pin_word_rx dut (
        .clk          (clk),
        .rst          (rst),
        .enable       (enable),
        .rx_pins      (rx_pins),
        .out_data     (out_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .err_parity   (err_parity),
        .err_overflow (err_overflow),
        .err_clear    (err_clear)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input logic [1:0] v);
        rx_pins = v;
        step();
    endtask

    // Start, eight LSB-first beats, parity; returns in cycle t+10.
    task automatic send_frame(input logic [15:0] w, input logic bad);
        beat(2'b01);
        for (int k = 0; k < 8; k++) beat(w[k*2 +: 2]);
        beat({1'b0, (^w) ^ bad});
        rx_pins = 2'b00;
    endtask

    initial begin
        rst       = 1'b1;
        enable    = 1'b1;
        rx_pins   = 2'b00;
        out_ready = 1'b0;
        err_clear = 1'b0;
        step();
        step();
        chk("rst_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_data", {16'd0, out_data}, 32'd0);
        chk("rst_perr", {31'd0, err_parity}, 32'd0);
        chk("rst_ovf", {31'd0, err_overflow}, 32'd0);
        rst = 1'b0;
        step();

        // Single good word, consumer always ready.
        out_ready = 1'b1;
        send_frame(16'hA5C3, 1'b0);
        chk("t1_valid_t10", {31'd0, out_valid}, 32'd0);
        step();
        chk("t1_valid_t11", {31'd0, out_valid}, 32'd1);
        chk("t1_data", {16'd0, out_data}, 32'h0000A5C3);
        step();
        chk("t1_valid_t12", {31'd0, out_valid}, 32'd0);
        chk("t1_perr", {31'd0, err_parity}, 32'd0);
        chk("t1_ovf", {31'd0, err_overflow}, 32'd0);

        // Bad parity.
        send_frame(16'hA5C3, 1'b1);
        chk("t2_perr_t10", {31'd0, err_parity}, 32'd0);
        step();
        chk("t2_perr_t11", {31'd0, err_parity}, 32'd1);
        chk("t2_valid", {31'd0, out_valid}, 32'd0);
        err_clear = 1'b1;
        step();
        err_clear = 1'b0;
        chk("t2_perr_clr", {31'd0, err_parity}, 32'd0);

        // Back-to-back frames with a stalled consumer.
        out_ready = 1'b0;
        send_frame(16'h0001, 1'b0);
        send_frame(16'hFFFF, 1'b0);
        send_frame(16'h1234, 1'b0);
        chk("t3_ovf_t10", {31'd0, err_overflow}, 32'd0);
        step();
        chk("t3_ovf_t11", {31'd0, err_overflow}, 32'd1);
        chk("t3_head0", {16'd0, out_data}, 32'h00000001);
        chk("t3_valid0", {31'd0, out_valid}, 32'd1);
        out_ready = 1'b1;
        step();
        chk("t3_head1", {16'd0, out_data}, 32'h0000FFFF);
        chk("t3_valid1", {31'd0, out_valid}, 32'd1);
        step();
        chk("t3_empty", {31'd0, out_valid}, 32'd0);
        chk("t3_perr", {31'd0, err_parity}, 32'd0);
        err_clear = 1'b1;
        step();
        err_clear = 1'b0;
        chk("t3_ovf_clr", {31'd0, err_overflow}, 32'd0);

        // Full FIFO, pop in the same cycle as the third push.
        out_ready = 1'b0;
        send_frame(16'h1111, 1'b0);
        send_frame(16'h2222, 1'b0);
        send_frame(16'h3333, 1'b0);
        chk("t4_head_pre", {16'd0, out_data}, 32'h00001111);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk("t4_ovf", {31'd0, err_overflow}, 32'd0);
        chk("t4_head_a", {16'd0, out_data}, 32'h00002222);
        out_ready = 1'b1;
        step();
        chk("t4_head_b", {16'd0, out_data}, 32'h00003333);
        chk("t4_valid_b", {31'd0, out_valid}, 32'd1);
        step();
        chk("t4_empty", {31'd0, out_valid}, 32'd0);
        chk("t4_ovf_end", {31'd0, err_overflow}, 32'd0);

        // Enable dropped after four data beats.
        out_ready = 1'b0;
        beat(2'b01);
        for (int k = 0; k < 4; k++) beat(2'b01);
        enable  = 1'b0;
        rx_pins = 2'b00;
        step();
        step();
        enable = 1'b1;
        step();
        step();
        chk("t5_valid_drop", {31'd0, out_valid}, 32'd0);
        chk("t5_perr_drop", {31'd0, err_parity}, 32'd0);
        send_frame(16'h5555, 1'b0);
        chk("t5_valid_t10", {31'd0, out_valid}, 32'd0);
        step();
        chk("t5_valid_t11", {31'd0, out_valid}, 32'd1);
        chk("t5_data", {16'd0, out_data}, 32'h00005555);
        chk("t5_perr", {31'd0, err_parity}, 32'd0);

        // Reset during beat 5 of a frame.
        send_frame(16'h1234, 1'b1);
        step();
        chk("t6_perr_set", {31'd0, err_parity}, 32'd1);
        beat(2'b01);
        for (int k = 0; k < 4; k++) beat(2'b01);
        rx_pins = 2'b10;
        #2;
        rst = 1'b1;
        #1;
        chk("t6_async_valid", {31'd0, out_valid}, 32'd0);
        chk("t6_async_data", {16'd0, out_data}, 32'h00000000);
        chk("t6_async_perr", {31'd0, err_parity}, 32'd0);
        step();
        rst = 1'b0;
        beat(2'b10);
        beat(2'b00);
        beat(2'b00);
        beat(2'b00);
        for (int k = 0; k < 12; k++) step();
        chk("t6_no_word", {31'd0, out_valid}, 32'd0);
        chk("t6_no_perr", {31'd0, err_parity}, 32'd0);
        out_ready = 1'b1;
        send_frame(16'hBEEF, 1'b0);
        chk("t6_valid_t10", {31'd0, out_valid}, 32'd0);
        step();
        chk("t6_valid_t11", {31'd0, out_valid}, 32'd1);
        chk("t6_data", {16'd0, out_data}, 32'h0000BEEF);
        step();
        chk("t6_empty", {31'd0, out_valid}, 32'd0);
        chk("t6_perr_end", {31'd0, err_parity}, 32'd0);
        chk("t6_ovf_end", {31'd0, err_overflow}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
